unified_mem_arb: RTL

- Synchronous, parametrised unified instruction/data memory for the processor.
- One shared word-addressed array serves two requesters: an instruction-fetch port and a data load/store port.
- A fixed-priority arbiter with an anti-starvation counter grants one access per cycle.
- Reads return after a configurable pipeline latency.
- Data writes support byte enables, and out-of-range accesses are flagged.

---
 rtl/unified_mem_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/unified_mem_arb.sv
// unified_mem_arb: shared instruction/data word memory with data-first
// arbitration, a fetch anti-starvation counter and a tagged read pipeline.
module unified_mem_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 65536,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_W-1:0]     if_data,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int LAST  = RD_LAT - 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic TAG_IF = 1'b0;
    localparam logic TAG_D  = 1'b1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              forced;

    logic [ADDR_W-1:0] acc_addr;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_oob;
    logic              acc_any;
    logic              rd_v;
    logic              rd_tag;
    logic [DATA_W-1:0] rd_data;

    logic [RD_LAT-1:0] pv_q;
    logic [RD_LAT-1:0] pv_d;
    logic [RD_LAT-1:0] pt_q;
    logic [RD_LAT-1:0] pt_d;
    logic [DATA_W-1:0] pd_q [RD_LAT];
    logic [DATA_W-1:0] pd_d [RD_LAT];

    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              err_q;

    // Data wins by default; a fetch denied STARVE_MAX times in a row wins next.
    always_comb begin
        forced = (starve_q == CNT_W'(STARVE_MAX));
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (forced) begin
                if_gnt = if_req;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req & ~d_req;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (!forced) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        acc_addr = if_gnt ? if_addr : d_addr;
        acc_idx  = acc_addr[IDX_W-1:0];
        acc_oob  = ({1'b0, acc_addr} >= DEPTH_L);
        acc_any  = if_gnt | d_gnt;
        rd_v     = if_gnt | (d_gnt & ~d_we);
        rd_tag   = if_gnt ? TAG_IF : TAG_D;
        rd_data  = '0;
        if (!acc_oob) begin
            rd_data = mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (d_gnt && d_we && !acc_oob) begin
            for (int i = 0; i < BE_W; i++) begin
                if (d_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= d_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        pv_d[0] = rd_v;
        pt_d[0] = rd_tag;
        pd_d[0] = rd_data;
        for (int k = 1; k < RD_LAT; k++) begin
            pv_d[k] = pv_q[k-1];
            pt_d[k] = pt_q[k-1];
            pd_d[k] = pd_q[k-1];
        end
    end

    // Output data registers load as the entry reaches the last stage,
    // so data and valid appear together and data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q      <= '0;
            pt_q      <= '0;
            starve_q  <= '0;
            err_q     <= 1'b0;
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            pv_q     <= pv_d;
            pt_q     <= pt_d;
            starve_q <= starve_d;
            err_q    <= acc_any & acc_oob;
            if (pv_d[LAST] && pt_d[LAST] == TAG_IF) begin
                if_data_q <= pd_d[LAST];
            end
            if (pv_d[LAST] && pt_d[LAST] == TAG_D) begin
                d_rdata_q <= pd_d[LAST];
            end
        end
    end

    always_ff @(posedge clk) begin
        pd_q <= pd_d;
    end

    assign if_valid = pv_q[LAST] & (pt_q[LAST] == TAG_IF);
    assign d_valid  = pv_q[LAST] & (pt_q[LAST] == TAG_D);
    assign if_data  = if_data_q;
    assign d_rdata  = d_rdata_q;
    assign err      = err_q;

endmodule
